ps2_key_rx: RTL and testbench
=============================

# ps2_key_rx

PS/2 keyboard receive front end for the Arkanoid build. Samples the raw `ps2k_clk`/`ps2k_data` pins in the 50 MHz `clk_in` domain and assembles 11-bit device-to-host frames with parity/stop/timeout checking. Decodes make/break/extended prefixes into held-key levels for paddle-left, paddle-right and fire. Sits directly upstream of the game display/logic block, which consumes `ps2_byte`, `ps2_state` and the key levels.

## Interface
- `FILTER_LEN`, 8: `clk_in` cycles a synchronized PS/2 line must be stable before its filtered value changes.
- `TIMEOUT_CYC`, 100000: idle `clk_in` cycles inside a frame before abort (2 ms at 50 MHz).
- `clk_in` in 1: 50 MHz system clock, single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `ps2k_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2k_data` in 1: raw PS/2 data pin, asynchronous.
- `ps2_byte` out 8: last correctly received byte, prefixes included.
- `rx_valid` out 1: one-cycle pulse when `ps2_byte` updates.
- `ps2_state` out 1: 1 after a make code, 0 after a break code.
- `key_left` out 1: held level, Left Arrow (E0 6B) or A (1C).
- `key_right` out 1: held level, Right Arrow (E0 74) or D (23).
- `key_fire` out 1: held level, Space (29).
- `frame_err` out 1: one-cycle pulse on parity, stop or timeout error.

## Operation
- Reset values: all outputs 0, FSM in IDLE, bit counter 0, prefix flags clear.
- Line conditioning: 2-FF synchronizer per pin, then a stability filter. The filtered value updates only after `FILTER_LEN` consecutive equal samples. Filtered clock and data reset to 1.
- Falling edge = filtered clock 1→0. All frame sampling happens on the falling edge only.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge, data 0 → DATA with count 0. Data 1 is ignored (glitch); stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: data 1 and odd parity over 8 data + parity bits → accept. Otherwise pulse `frame_err` and discard. In both cases → IDLE.
- Timeout: a counter clears on every edge and runs in any non-IDLE state. When it reaches `TIMEOUT_CYC`: pulse `frame_err`, discard the partial byte, → IDLE. It never runs in IDLE.
- Accept: load `ps2_byte` and pulse `rx_valid` in the same cycle.
- Decoder, on each accepted byte:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - Any other code: match against the key map using `ext`. A hit sets the key (make) or clears it (break). `ps2_state` ← ~`brk`. Then clear `ext` and `brk`.
- Non-extended 6B or 74 (keypad) matches nothing. Unmapped codes still update `ps2_state`.
- Typematic repeat makes re-set an already-set key: no change, no extra event.
- `frame_err` clears `ext` and `brk`. Key levels are unchanged.

## Timing
- Pin to filtered value: 2 + `FILTER_LEN` cycles, plus 1 for the edge register.
- `rx_valid` and the new `ps2_byte` assert 1 cycle after the filtered falling edge that samples the stop bit. Key levels and `ps2_state` update in that same cycle.
- `rx_valid` and `frame_err` are never high together. Each is exactly 1 cycle wide.
- If a timeout expires on the same cycle as an edge arrives, the edge wins and the counter clears.
- `reset` asserted mid-frame forces IDLE immediately and clears everything. The first frame after release needs a fresh start bit.
- A timeout-aborted frame produces no `rx_valid`.

## Structure
- `ps2_pkg`: FSM state enum, scan-code constants (E0, F0, 6B, 74, 1C, 23, 29), default filter/timeout values.
- Sub-module `ps2_line_filter`: synchronizer plus stability filter, instantiated once per pin, parameterized by `FILTER_LEN`.
- Top: FSM, shift register, parity, timeout counter, decoder flags, key registers.

## Test plan
Benches use `FILTER_LEN`=4 and `TIMEOUT_CYC`=2000, with a 2 µs PS/2 bit period.
1. Frame 0x29 with good parity → `ps2_byte`=29, one `rx_valid` pulse; `key_fire`=1, `ps2_state`=1. Then F0 29 → `key_fire`=0, `ps2_state`=0.
2. E0 6B then E0 F0 6B → `key_left` 1 then 0. Plain 6B → `key_left` stays 0, `ps2_byte`=6B.
3. Frame 0x1C with parity bit inverted → `frame_err` pulse, no `rx_valid`, `key_left`=0. Next good 1C → `key_left`=1.
4. Stop clocks after 4 data bits → `frame_err` exactly 2000 cycles after the last edge. Next full 0x23 frame → `key_right`=1.
5. 3-cycle low glitch on `ps2k_clk` while idle → no state change, no pulses.
6. `reset` pulsed mid-frame with `key_right`=1 held → all outputs 0. A following clean E0 74 → `key_right`=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Scan codes, FSM states and default conditioning/timeout values.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_6B = 8'h6B;
  localparam logic [7:0] SC_74 = 8'h74;
  localparam logic [7:0] SC_1C = 8'h1C;
  localparam logic [7:0] SC_23 = 8'h23;
  localparam logic [7:0] SC_29 = 8'h29;

  localparam int FILTER_LEN_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 100000;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one PS/2 pin.
// The level only moves after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_in,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receive front end: frame assembly, error checks and
// make/break decoding into held paddle-left/right and fire levels.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       rx_valid,
  output logic       ps2_state,
  output logic       key_left,
  output logic       key_right,
  output logic       key_fire,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_f;
  logic          dat_f;
  logic          clk_q;
  logic          fall;
  rx_state_e     state;
  rx_state_e     state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tmo;
  logic          accept;
  logic          bad;
  logic          ext;
  logic          brk;
  logic          hit_l;
  logic          hit_r;
  logic          hit_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_in (clk_in),
    .reset  (reset),
    .pin    (ps2k_clk),
    .level  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_in (clk_in),
    .reset  (reset),
    .pin    (ps2k_data),
    .level  (dat_f)
  );

  assign fall = clk_q & ~clk_f;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      clk_q <= 1'b1;
    end else begin
      state <= state_n;
      clk_q <= clk_f;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall && !dat_f) state_n = DATA;
      end
      DATA: begin
        if (fall && bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: begin
        if (fall) state_n = STOP;
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (dat_f && ^{shift, par}) accept = 1'b1;
          else bad = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // An edge on the expiry cycle keeps the frame alive.
    if (!fall && state != IDLE && tmo == TW'(TIMEOUT_CYC - 1)) begin
      state_n = IDLE;
      bad     = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
    end else begin
      if (state == IDLE || fall) tmo <= '0;
      else tmo <= tmo + 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shift   <= {dat_f, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) par <= dat_f;
    end
  end

  always_comb begin
    hit_l = ext ? (shift == SC_6B) : (shift == SC_1C);
    hit_r = ext ? (shift == SC_74) : (shift == SC_23);
    hit_f = !ext && (shift == SC_29);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ps2_byte  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      ps2_state <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_fire  <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else begin
      rx_valid  <= accept;
      frame_err <= bad;
      if (bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (accept) begin
        ps2_byte <= shift;
        unique case (1'b1)
          (shift == SC_E0): ext <= 1'b1;
          (shift == SC_F0): brk <= 1'b1;
          default: begin
            ps2_state <= ~brk;
            if (hit_l) key_left  <= ~brk;
            if (hit_r) key_right <= ~brk;
            if (hit_f) key_fire  <= ~brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: directed PS/2 frames with
// hand-computed byte/key expectations checked by a monitor process.
module tb_ps2_key_rx;

  localparam int FL  = 4;
  localparam int TO  = 2000;
  localparam int HP  = 10;
  localparam int CYC = 2 * HP;

  logic       clk_in    = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2k_clk  = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       rx_valid;
  logic       ps2_state;
  logic       key_left;
  logic       key_right;
  logic       key_fire;
  logic       frame_err;

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .ps2k_clk  (ps2k_clk),
    .ps2k_data (ps2k_data),
    .ps2_byte  (ps2_byte),
    .rx_valid  (rx_valid),
    .ps2_state (ps2_state),
    .key_left  (key_left),
    .key_right (key_right),
    .key_fire  (key_fire),
    .frame_err (frame_err)
  );

  always #HP clk_in = ~clk_in;

  // lv = {left, right, fire, state}
  typedef struct packed {
    logic       err;
    logic [7:0] b;
    logic [3:0] lv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  time  t_err  = 0;
  time  t_edge = 0;

  always @(negedge clk_in) begin
    if (rx_valid && frame_err) begin
      n_vec++;
      n_bad++;
      $display("FAIL overlap: rx_valid and frame_err both high");
    end else if (rx_valid || frame_err) begin
      if (frame_err) t_err = $time;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected event: rx_valid=%0b frame_err=%0b byte=%h",
                 rx_valid, frame_err, ps2_byte);
      end else begin
        e = q.pop_front();
        n_vec++;
        if (frame_err != e.err || (!e.err && ps2_byte != e.b) ||
            {key_left, key_right, key_fire, ps2_state} != e.lv) begin
          n_bad++;
          $display("FAIL event %h: got err=%0b byte=%h lv=%b, need err=%0b byte=%h lv=%b",
                   e.b, frame_err, ps2_byte,
                   {key_left, key_right, key_fire, ps2_state},
                   e.err, e.b, e.lv);
        end
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic badpar);
    return {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction

  task automatic bit_out(input logic d);
    ps2k_data = d;
    #(25 * CYC);
    ps2k_clk = 1'b0;
    t_edge = $time;
    #(50 * CYC);
    ps2k_clk = 1'b1;
    #(25 * CYC);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) bit_out(f[i]);
    ps2k_data = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (q.size() != 0 && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: %0d expected events never seen, need 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input logic badpar, input logic [3:0] lv);
    q.push_back({badpar, b, lv});
    send_bits(mk(b, badpar), 11);
    #(10 * CYC);
    drain("frame");
  endtask

  task automatic check_zero(input string name);
    logic [12:0] got;
    got = {ps2_byte, rx_valid, ps2_state, key_left, key_right, key_fire};
    n_vec++;
    if (got != 13'd0 || frame_err) begin
      n_bad++;
      $display("FAIL %s: outputs=%h frame_err=%0b, need all 0", name, got, frame_err);
    end
  endtask

  initial begin
    int lat;
    repeat (5) @(negedge clk_in);
    check_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk_in);

    // make/break of fire
    send(8'h29, 1'b0, 4'b0011);
    send(8'hF0, 1'b0, 4'b0011);
    send(8'h29, 1'b0, 4'b0000);
    // extended left arrow make/break, keypad 6B ignored
    send(8'hE0, 1'b0, 4'b0000);
    send(8'h6B, 1'b0, 4'b1001);
    send(8'hE0, 1'b0, 4'b1001);
    send(8'hF0, 1'b0, 4'b1001);
    send(8'h6B, 1'b0, 4'b0000);
    send(8'h6B, 1'b0, 4'b0001);
    // bad parity, then good A
    send(8'h1C, 1'b1, 4'b0001);
    send(8'h1C, 1'b0, 4'b1001);

    // timeout after 4 data bits
    q.push_back({1'b1, 8'h00, 4'b1001});
    send_bits(mk(8'h23, 1'b0), 5);
    drain("timeout");
    lat = int'((t_err - t_edge) / CYC);
    n_vec++;
    if (lat < TO + 3 || lat > TO + 12) begin
      n_bad++;
      $display("FAIL timeout latency: %0d cycles, need %0d..%0d", lat, TO + 3, TO + 12);
    end
    send(8'h23, 1'b0, 4'b1101);

    // short clock glitch while idle
    ps2k_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    ps2k_clk = 1'b1;
    repeat (50) @(negedge clk_in);
    n_vec++;
    if ({key_left, key_right, key_fire, ps2_state} != 4'b1101 || ps2_byte != 8'h23) begin
      n_bad++;
      $display("FAIL glitch: lv=%b byte=%h, need lv=1101 byte=23",
               {key_left, key_right, key_fire, ps2_state}, ps2_byte);
    end
    send(8'h29, 1'b0, 4'b1111);

    // reset mid-frame
    send_bits(mk(8'h74, 1'b0), 4);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    check_zero("reset mid-frame");
    reset = 1'b0;
    repeat (TO + 100) @(negedge clk_in);
    check_zero("after reset release");
    send(8'hE0, 1'b0, 4'b0000);
    send(8'h74, 1'b0, 4'b0101);
    // typematic repeat
    send(8'hE0, 1'b0, 4'b0101);
    send(8'h74, 1'b0, 4'b0101);

    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL final queue: %0d left, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
